// File: rtl/cmp_speed_pkg.sv
// Shared types, default seeds and the xorshift64 step for the cmp_speed driver.
package cmp_speed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [63:0] DEFAULT_SEED_A = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] DEFAULT_SEED_B = 64'hD1B54A32D192ED03;

    // One xorshift64 step: x ^= x << 13; x ^= x >> 7; x ^= x << 17.
    function automatic logic [63:0] xorshift64_next(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 6'd13);
        t = t ^ (t >> 6'd7);
        t = t ^ (t << 6'd17);
        return t;
    endfunction

endpackage

// File: rtl/cmp_speed_if.sv
// Operand/result link between the driver and the registered comparator under test.
interface cmp_speed_if #(
    parameter int DATA_BITS = 32
);
    logic                 dut_cke;
    logic [DATA_BITS-1:0] dut_a;
    logic [DATA_BITS-1:0] dut_b;
    logic                 dut_c;

    modport master (
        output dut_cke,
        output dut_a,
        output dut_b,
        input  dut_c
    );

    modport slave (
        input  dut_cke,
        input  dut_a,
        input  dut_b,
        output dut_c
    );
endinterface

// File: rtl/cmp_speed_xorshift64.sv
// xorshift64 operand generator: reloadable, advances on step, exposes low OUT_BITS of its state.
module cmp_speed_xorshift64
    import cmp_speed_pkg::*;
#(
    parameter int          OUT_BITS   = 32,
    parameter logic [63:0] RESET_SEED = DEFAULT_SEED_A
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [63:0]         seed,
    output logic [OUT_BITS-1:0] state
);
    logic [63:0] state_r;

    assign state = state_r[OUT_BITS-1:0];

    // Generator state: reload has priority over advancing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RESET_SEED;
        end else if (load) begin
            state_r <= seed;
        end else if (step) begin
            state_r <= xorshift64_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end
endmodule

// File: rtl/cmp_speed_driver.sv
// Drives pseudo-random operand pairs into a registered a>b comparator and scores its answers.
module cmp_speed_driver
    import cmp_speed_pkg::*;
#(
    parameter int          DATA_BITS = 32,
    parameter int          ITER_BITS = 32,
    parameter int          CNT_BITS  = 32,
    parameter logic [63:0] SEED_A    = DEFAULT_SEED_A,
    parameter logic [63:0] SEED_B    = DEFAULT_SEED_B
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ITER_BITS-1:0] iterations,
    output logic                 busy,
    output logic                 done,
    cmp_speed_if.master          cmp,
    output logic [CNT_BITS-1:0]  gt_count,
    output logic [CNT_BITS-1:0]  err_count
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    // The seed pair is presented straight from the accept edge, so the generators are
    // reloaded one step ahead and always hold the next pair to issue.
    localparam logic [DATA_BITS-1:0] FIRST_A = SEED_A[DATA_BITS-1:0];
    localparam logic [DATA_BITS-1:0] FIRST_B = SEED_B[DATA_BITS-1:0];
    localparam logic [63:0]          LOAD_A  = xorshift64_next(SEED_A);
    localparam logic [63:0]          LOAD_B  = xorshift64_next(SEED_B);

    logic [1:0]           state_r;
    logic [ITER_BITS-1:0] remaining_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 cke_r;
    logic [DATA_BITS-1:0] a_r;
    logic [DATA_BITS-1:0] b_r;
    logic                 exp_r;
    logic                 chk_v_r;
    logic [CNT_BITS-1:0]  gt_r;
    logic [CNT_BITS-1:0]  err_r;
    logic                 load_s;
    logic                 step_s;
    logic [DATA_BITS-1:0] a_next_s;
    logic [DATA_BITS-1:0] b_next_s;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v, input logic inc);
        if (inc && (v != {CNT_BITS{1'b1}})) begin
            return v + CNT_BITS'(1);
        end else begin
            return v;
        end
    endfunction

    cmp_speed_xorshift64 #(.OUT_BITS(DATA_BITS), .RESET_SEED(SEED_A)) u_prng_a (
        .clk(clk), .reset(reset), .load(load_s), .step(step_s), .seed(LOAD_A), .state(a_next_s)
    );

    cmp_speed_xorshift64 #(.OUT_BITS(DATA_BITS), .RESET_SEED(SEED_B)) u_prng_b (
        .clk(clk), .reset(reset), .load(load_s), .step(step_s), .seed(LOAD_B), .state(b_next_s)
    );

    // Generator control: reload on an accepted start, advance while further pairs remain.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        if (state_r == ST_IDLE) begin
            load_s = start;
        end else if (state_r == ST_RUN) begin
            step_s = (remaining_r != ITER_BITS'(1));
        end else begin
            load_s = 1'b0;
            step_s = 1'b0;
        end
    end

    // Run sequencer: accept, issue pairs, let the last result arrive, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cke_r       <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r      <= 1'b1;
                        remaining_r <= iterations;
                        if (iterations != '0) begin
                            state_r <= ST_RUN;
                            cke_r   <= 1'b1;
                            a_r     <= FIRST_A;
                            b_r     <= FIRST_B;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (remaining_r == ITER_BITS'(1)) begin
                        state_r <= ST_DRAIN;
                        cke_r   <= 1'b0;
                        a_r     <= '0;
                        b_r     <= '0;
                    end else begin
                        remaining_r <= remaining_r - ITER_BITS'(1);
                        cke_r       <= 1'b1;
                        a_r         <= a_next_s;
                        b_r         <= b_next_s;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cke_r   <= 1'b0;
                end
            endcase
        end
    end

    // Reference answer and its valid flag, aligned with the comparator's one-cycle latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_r   <= 1'b0;
            chk_v_r <= 1'b0;
        end else begin
            exp_r   <= (a_r > b_r);
            chk_v_r <= cke_r;
        end
    end

    // Score counters: cleared on accept, saturating, held between runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gt_r  <= '0;
            err_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            gt_r  <= '0;
            err_r <= '0;
        end else if (chk_v_r) begin
            gt_r  <= sat_inc(gt_r, cmp.dut_c);
            err_r <= sat_inc(err_r, cmp.dut_c != exp_r);
        end else begin
            gt_r  <= gt_r;
            err_r <= err_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign cmp.dut_cke = cke_r;
    assign cmp.dut_a   = a_r;
    assign cmp.dut_b   = b_r;
    assign gt_count    = gt_r;
    assign err_count   = err_r;
endmodule

// File: tb/tb_cmp_speed_driver.sv
// Self-checking bench for cmp_speed_driver: behavioural run model plus directed and random runs.
module tb_cmp_speed_driver;
    localparam int     DB    = 32;
    localparam int     MAXIT = 1000;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        start      = 1'b0;
    logic [31:0] iterations = 32'd0;
    logic        busy, done;
    logic [31:0] gt_count, err_count;
    logic        start4      = 1'b0;
    logic [31:0] iterations4 = 32'd0;
    logic        busy4, done4;
    logic [3:0]  gt4, err4;
    int          mode  = 0;
    int          mode4 = 0;
    int          checks = 0;
    int          errors = 0;

    cmp_speed_if #(.DATA_BITS(DB)) cif ();
    cmp_speed_if #(.DATA_BITS(DB)) cif4 ();

    cmp_speed_driver #(.DATA_BITS(DB), .ITER_BITS(32), .CNT_BITS(32)) dut (
        .clk(clk), .reset(reset), .start(start), .iterations(iterations),
        .busy(busy), .done(done), .cmp(cif), .gt_count(gt_count), .err_count(err_count)
    );

    cmp_speed_driver #(.DATA_BITS(DB), .ITER_BITS(32), .CNT_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .iterations(iterations4),
        .busy(busy4), .done(done4), .cmp(cif4), .gt_count(gt4), .err_count(err4)
    );

    always #5 clk = ~clk;

    // Comparators under test: 0 ideal, 1 stuck at 0, 2 inverted
    always @(posedge clk) begin
        if (cif.dut_cke) begin
            case (mode)
                1:       cif.dut_c <= 1'b0;
                2:       cif.dut_c <= !(cif.dut_a > cif.dut_b);
                default: cif.dut_c <= (cif.dut_a > cif.dut_b);
            endcase
        end
    end

    always @(posedge clk) begin
        if (cif4.dut_cke) begin
            case (mode4)
                1:       cif4.dut_c <= 1'b0;
                2:       cif4.dut_c <= !(cif4.dut_a > cif4.dut_b);
                default: cif4.dut_c <= (cif4.dut_a > cif4.dut_b);
            endcase
        end
    end

    // Operand sequences and prefix counts of a>b
    logic [31:0] sa [MAXIT];
    logic [31:0] sb [MAXIT];
    int          pgt [MAXIT+1];

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // Expected counter after m checked pairs under comparator mode md
    function automatic longint cnt_model(input int m, input int md, input bit want_err, input longint maxv);
        longint v;
        case (md)
            1:       v = want_err ? longint'(pgt[m]) : 0;
            2:       v = want_err ? longint'(m) : longint'(m - pgt[m]);
            default: v = want_err ? 0 : longint'(pgt[m]);
        endcase
        if (v > maxv) v = maxv;
        return v;
    endfunction

    function automatic int done_p(input int it);
        return (it == 0) ? 1 : it + 2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run model: m_p counts cycles since the accept edge (cycle 1 carries the first pair)
    bit     m_act = 1'b0;
    int     m_p   = 0;
    int     m_it  = 0;
    int     m_md  = 0;
    longint m_gt  = 0;
    longint m_err = 0;

    always @(posedge clk or posedge reset) begin
        int m;
        if (reset) begin
            m_act = 1'b0;
            m_p   = 0;
            m_gt  = 0;
            m_err = 0;
        end else begin
            if (m_act) begin
                m_p++;
                if (m_p > done_p(m_it)) m_act = 1'b0;
            end else if (start) begin
                m_act = 1'b1;
                m_p   = 1;
                m_it  = int'(iterations);
                m_md  = mode;
            end
            if (m_act) begin
                m = m_p - 2;
                if (m < 0) m = 0;
                if (m > m_it) m = m_it;
                m_gt  = cnt_model(m, m_md, 1'b0, MAX32);
                m_err = cnt_model(m, m_md, 1'b1, MAX32);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        bit e_cke;
        e_cke = m_act && (m_p <= m_it);
        chk("busy", busy, m_act);
        chk("done", done, m_act && (m_p == done_p(m_it)));
        chk("cke", cif.dut_cke, e_cke);
        chk("gt_count", gt_count, m_gt);
        chk("err_count", err_count, m_err);
        if (e_cke) begin
            chk("dut_a", cif.dut_a, sa[m_p-1]);
            chk("dut_b", cif.dut_b, sb[m_p-1]);
        end
    end

    task automatic run(input int it, input int md, input int glitch,
                       output int lat, output logic [31:0] fa, output logic [31:0] fb);
        @(posedge clk); #1;
        mode = md; iterations = it; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; iterations = $urandom;
        lat = 0; fa = 32'd0; fb = 32'd0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin fa = cif.dut_a; fb = cif.dut_b; end
            if (done) break;
            if (lat > it + 10) break;
            if (lat == glitch) begin start = 1'b1; iterations = $urandom_range(1, 5); end
            else start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [63:0] xa, xb;
        logic [31:0] fa, fb;
        int lat, it, md, gl;

        xa = 64'h9E3779B97F4A7C15;
        xb = 64'hD1B54A32D192ED03;
        pgt[0] = 0;
        for (int i = 0; i < MAXIT; i++) begin
            sa[i] = xa[31:0];
            sb[i] = xb[31:0];
            pgt[i+1] = pgt[i] + ((xa[31:0] > xb[31:0]) ? 1 : 0);
            xa = xs(xa);
            xb = xs(xb);
        end
        chk("pin_pgt1", pgt[1], 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_cke", cif.dut_cke, 1'b0);
        chk("rst_gt", gt_count, 32'd0);
        reset = 1'b0;

        // Single pair: literal seeds, latency 3
        run(1, 0, 0, lat, fa, fb);
        chk("s1_lat", lat, 3);
        chk("s1_a", fa, 32'h7F4A7C15);
        chk("s1_b", fb, 32'hD192ED03);
        chk("s1_gt", gt_count, 32'd0);
        chk("s1_err", err_count, 32'd0);

        // Zero iterations: done right after accept
        run(0, 0, 0, lat, fa, fb);
        chk("s4_lat", lat, 1);
        chk("s4_gt", gt_count, 32'd0);

        // Long ideal run, then stuck-at-0 comparator
        run(1000, 0, 0, lat, fa, fb);
        chk("s2_lat", lat, 1002);
        chk("s2_gt", gt_count, pgt[1000]);
        chk("s2_err", err_count, 32'd0);
        run(1000, 1, 0, lat, fa, fb);
        chk("s3_gt", gt_count, 32'd0);
        chk("s3_err", err_count, pgt[1000]);

        // Reset in the middle of a run, then rerun
        @(posedge clk); #1;
        mode = 0; iterations = 1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (500) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("s5_busy", busy, 1'b0);
        chk("s5_cke", cif.dut_cke, 1'b0);
        chk("s5_a", cif.dut_a, 32'd0);
        chk("s5_gt", gt_count, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        run(1000, 0, 0, lat, fa, fb);
        chk("s5_rerun_gt", gt_count, pgt[1000]);
        chk("s5_rerun_a", fa, 32'h7F4A7C15);

        // 4-bit counters saturate; start during RUN ignored
        @(posedge clk); #1;
        mode4 = 2; iterations4 = 20; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (done4 || lat > 40) break;
            if (lat == 5) begin start4 = 1'b1; iterations4 = 7; end
            else start4 = 1'b0;
        end
        start4 = 1'b0;
        chk("s6_lat", lat, 22);
        chk("s6_busy", busy4, 1'b1);
        chk("s6_err", err4, 4'd15);
        chk("s6_gt", gt4, cnt_model(20, 2, 1'b0, 15));
        repeat (4) @(negedge clk);
        chk("s6_idle", busy4, 1'b0);
        chk("s6_hold", err4, 4'd15);

        // Random runs with stray start pulses
        for (int r = 0; r < 12; r++) begin
            it = $urandom_range(0, 60);
            md = $urandom_range(0, 2);
            gl = $urandom_range(1, it + 3);
            run(it, md, gl, lat, fa, fb);
            chk("rnd_lat", lat, done_p(it));
            chk("rnd_gt", gt_count, cnt_model(it, md, 1'b0, MAX32));
            chk("rnd_err", err_count, cnt_model(it, md, 1'b1, MAX32));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
